// File: rtl/adc_pkg.sv
// Shared definitions for the MAX1282 scan path: sizes, scheduler FSM encoding
// and the left-justified result padding used by every result consumer.
package adc_pkg;

  localparam int NUM_CH   = 4;
  localparam int RES_W    = 12;
  localparam int CH_W     = 2;
  localparam int PERIOD_W = 16;
  localparam int TIMEOUT  = 4096;
  localparam int RESULT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4
  } scan_state_e;

  function automatic logic [RESULT_W-1:0] pad_result(input logic [RES_W-1:0] data);
    return {data, {(RESULT_W-RES_W){1'b0}}};
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Scan period timer: counts 0..period while enabled and emits a one-cycle tick
// on the terminal count; held at zero with no ticks while disabled.
module adc_period_timer
  import adc_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;

  // Count/reload; >= keeps the timer sane if period shrinks below the count.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q >= period) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Shares the MAX1282 conversion engine between periodic channel scans and
// single-shot host requests; host wins at conversion boundaries.
module adc_scan_scheduler
  import adc_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cfg_en,
  input  logic [NUM_CH-1:0]   cfg_ch_mask,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                host_req,
  input  logic [CH_W-1:0]     host_ch,
  output logic                host_ack,
  output logic                adc_start,
  output logic [CH_W-1:0]     adc_ch,
  input  logic                adc_done,
  input  logic [RES_W-1:0]    adc_data,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [RESULT_W-1:0] res_data,
  output logic                res_host,
  output logic                frame_done,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  scan_state_e         state_q, state_d;
  logic                scan_pending_q, scan_pending_d;
  logic [NUM_CH-1:0]   scan_mask_q, scan_mask_d;
  logic [CH_W-1:0]     scan_ptr_q, scan_ptr_d;
  logic                sel_host_q, sel_host_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                host_ack_q, host_ack_d;
  logic                adc_start_q, adc_start_d;
  logic [CH_W-1:0]     adc_ch_q, adc_ch_d;
  logic                res_valid_q, res_valid_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [RESULT_W-1:0] res_data_q, res_data_d;
  logic                res_host_q, res_host_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;

  logic                tick;
  logic                scan_active;
  logic [CH_W-1:0]     scan_sel;
  logic [NUM_CH-1:0]   mask_after;

  adc_period_timer u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (cfg_en),
    .period    (cfg_period),
    .tick      (tick)
  );

  // A scan conversion in flight blocks a new scan even if pending was dropped by cfg_en.
  assign scan_active = !sel_host_q && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));

  // Lowest remaining scan channel at or above the scan pointer.
  always_comb begin
    scan_sel = scan_ptr_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan_sel = (scan_mask_q[i] && (CH_W'(i) >= scan_ptr_q)) ? CH_W'(i) : scan_sel;
    end
  end

  // Next-state, arbitration, scan bookkeeping and staging of registered outputs.
  always_comb begin
    state_d        = state_q;
    scan_pending_d = scan_pending_q;
    scan_mask_d    = scan_mask_q;
    scan_ptr_d     = scan_ptr_q;
    sel_host_d     = sel_host_q;
    tmo_cnt_d      = tmo_cnt_q;
    adc_ch_d       = adc_ch_q;
    res_ch_d       = res_ch_q;
    res_data_d     = res_data_q;
    res_host_d     = res_host_q;
    overrun_d      = overrun_q;
    timeout_err_d  = timeout_err_q;
    host_ack_d     = 1'b0;
    adc_start_d    = 1'b0;
    res_valid_d    = 1'b0;
    frame_done_d   = 1'b0;
    mask_after     = scan_mask_q;

    case (state_q)
      ST_IDLE: begin
        if (host_req || scan_pending_q) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (host_req) begin
          adc_ch_d    = host_ch;
          sel_host_d  = 1'b1;
          adc_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end else if (scan_pending_q) begin
          adc_ch_d    = scan_sel;
          sel_host_d  = 1'b0;
          scan_ptr_d  = scan_sel + CH_W'(1);
          adc_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc_done || (tmo_cnt_q == TMO_LAST)) begin
          state_d     = ST_STORE;
          res_valid_d = 1'b1;
          res_ch_d    = adc_ch_q;
          res_host_d  = sel_host_q;
          host_ack_d  = sel_host_q;
          if (adc_done) begin
            res_data_d = pad_result(adc_data);
          end else begin
            res_data_d    = '0;
            timeout_err_d = 1'b1;
          end
          if (!sel_host_q && scan_pending_q) begin
            mask_after  = scan_mask_q & ~(NUM_CH'(1) << adc_ch_q);
            scan_mask_d = mask_after;
            if (mask_after == '0) begin
              frame_done_d   = 1'b1;
              scan_pending_d = 1'b0;
            end else begin
              frame_done_d = 1'b0;
            end
          end else begin
            scan_mask_d = scan_mask_q;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          state_d   = ST_WAIT;
        end
      end
      ST_STORE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tick) begin
      if (scan_pending_q || scan_active) begin
        overrun_d = 1'b1;
      end else if (cfg_ch_mask != '0) begin
        scan_pending_d = 1'b1;
        scan_mask_d    = cfg_ch_mask;
        scan_ptr_d     = '0;
      end else begin
        scan_pending_d = scan_pending_q;
      end
    end else begin
      overrun_d = overrun_q;
    end

    // Disabling scanning abandons the rest of the frame without a frame_done.
    if (!cfg_en) begin
      scan_pending_d = 1'b0;
      scan_mask_d    = '0;
      frame_done_d   = 1'b0;
    end else begin
      scan_pending_d = scan_pending_d;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      scan_pending_q <= 1'b0;
      scan_mask_q    <= '0;
      scan_ptr_q     <= '0;
      sel_host_q     <= 1'b0;
      tmo_cnt_q      <= '0;
      host_ack_q     <= 1'b0;
      adc_start_q    <= 1'b0;
      adc_ch_q       <= '0;
      res_valid_q    <= 1'b0;
      res_ch_q       <= '0;
      res_data_q     <= '0;
      res_host_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      scan_pending_q <= scan_pending_d;
      scan_mask_q    <= scan_mask_d;
      scan_ptr_q     <= scan_ptr_d;
      sel_host_q     <= sel_host_d;
      tmo_cnt_q      <= tmo_cnt_d;
      host_ack_q     <= host_ack_d;
      adc_start_q    <= adc_start_d;
      adc_ch_q       <= adc_ch_d;
      res_valid_q    <= res_valid_d;
      res_ch_q       <= res_ch_d;
      res_data_q     <= res_data_d;
      res_host_q     <= res_host_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign host_ack    = host_ack_q;
  assign adc_start   = adc_start_q;
  assign adc_ch      = adc_ch_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign res_host    = res_host_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized bench: an ADC engine stand-in answers conversions, and expected
// channel order, data and cycle timing are derived from the scan/host rules.
module tb_adc_scan_scheduler;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        cfg_en;
  logic [3:0]  cfg_ch_mask;
  logic [15:0] cfg_period;
  logic        host_req;
  logic [1:0]  host_ch;
  logic        host_ack;
  logic        adc_start;
  logic [1:0]  adc_ch;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [15:0] res_data;
  logic        res_host;
  logic        frame_done;
  logic        overrun;
  logic        timeout_err;

  adc_scan_scheduler dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cfg_en      (cfg_en),
    .cfg_ch_mask (cfg_ch_mask),
    .cfg_period  (cfg_period),
    .host_req    (host_req),
    .host_ch     (host_ch),
    .host_ack    (host_ack),
    .adc_start   (adc_start),
    .adc_ch      (adc_ch),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .res_valid   (res_valid),
    .res_ch      (res_ch),
    .res_data    (res_data),
    .res_host    (res_host),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  ch;
    logic [15:0] data;
    logic        host;
    logic        ack;
    logic        fd;
  } res_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  res_t        res_log[$];
  int          start_log[$];
  int          fd_log[$];
  int          done_cyc[$];
  logic [11:0] done_dat[$];
  int          eng_delay = 10;
  bit          eng_mute = 1'b0;
  bit          eng_fix = 1'b0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Passive log of DUT events, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (adc_start) start_log.push_back(cyc);
      if (res_valid) res_log.push_back('{cyc, res_ch, res_data, res_host, host_ack, frame_done});
      if (frame_done) fd_log.push_back(cyc);
    end
  end

  // Engine model: answers each start after eng_delay cycles unless muted or reset.
  initial begin : engine
    bit          aborted;
    logic [11:0] val;
    adc_done = 1'b0;
    adc_data = 12'h000;
    forever begin
      @(negedge sys_clk);
      if (adc_start === 1'b1 && !eng_mute) begin
        aborted = 1'b0;
        for (int j = 0; j < eng_delay; j++) begin
          @(posedge sys_clk);
          if (!sys_rst_n) aborted = 1'b1;
        end
        if (!aborted && sys_rst_n) begin
          #1;
          val = eng_fix ? 12'hABC : 12'($urandom_range(4095, 0));
          adc_data = val;
          adc_done = 1'b1;
          done_cyc.push_back(cyc);
          done_dat.push_back(val);
          @(posedge sys_clk);
          #1;
          adc_done = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int c = 0;
    while (start_log.size() < n && c < budget) begin next_cyc(); c++; end
    check_eq(tag, 32'(start_log.size() >= n), 32'd1);
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int c = 0;
    while (fd_log.size() < n && c < budget) begin next_cyc(); c++; end
    check_eq(tag, 32'(fd_log.size() >= n), 32'd1);
  endtask

  task automatic quiesce();
    cfg_en   = 1'b0;
    host_req = 1'b0;
    eng_mute = 1'b0;
    repeat (120) next_cyc();
    res_log.delete(); start_log.delete(); fd_log.delete();
    done_cyc.delete(); done_dat.delete();
  endtask

  function automatic logic [31:0] outs_vec();
    return {host_ack, adc_start, adc_ch, res_valid, res_ch, res_data, res_host,
            frame_done, overrun, timeout_err};
  endfunction

  task automatic run_scan(input logic [3:0] m, input int p, input int d, input bit fixed);
    int          k;
    int          n;
    int          exp_ch[$];
    logic [15:0] exp_data;
    quiesce();
    eng_delay = d; eng_fix = fixed;
    cfg_ch_mask = m; cfg_period = 16'(p);
    @(posedge sys_clk); #1;
    cfg_en = 1'b1;
    k = cyc;
    wait_frames(2, 2 * (p + 1) + 600, "scan_frames");
    n = $countones(m);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++)
        if (m[c]) exp_ch.push_back(c);
    check_eq("scan_first_start", (start_log.size() > 0) ? start_log[0] : -1, k + p + 3);
    check_eq("scan_res_count", res_log.size(), exp_ch.size());
    for (int i = 0; i < exp_ch.size() && i < res_log.size() && i < done_dat.size(); i++) begin
      exp_data = fixed ? 16'hABC0 : {done_dat[i], 4'h0};
      check_eq($sformatf("scan_ch[%0d]", i), res_log[i].ch, exp_ch[i]);
      check_eq($sformatf("scan_data[%0d]", i), res_log[i].data, exp_data);
      check_eq($sformatf("scan_host[%0d]", i), res_log[i].host, 0);
      check_eq($sformatf("scan_lat[%0d]", i), res_log[i].cyc, done_cyc[i] + 1);
      check_eq($sformatf("scan_fd[%0d]", i), res_log[i].fd, 32'((i % n) == (n - 1)));
    end
    if (fd_log.size() >= 2) check_eq("scan_frame_spacing", fd_log[1] - fd_log[0], p + 1);
    else check_eq("scan_frame_spacing", fd_log.size(), 2);
    check_eq("scan_overrun", overrun, 0);
  endtask

  initial begin : main
    int          k, s, r, h, c;
    logic [1:0]  hc;
    int          ech[$];
    int          ehost[$];

    sys_rst_n = 1'b0; cfg_en = 1'b0; cfg_ch_mask = 4'h0; cfg_period = 16'd0;
    host_req = 1'b0; host_ch = 2'd0;
    repeat (3) next_cyc();
    check_eq("reset_outputs", outs_vec(), 32'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    run_scan(4'b1111, 1000, 50, 1'b1);
    run_scan(4'b1010, 300, 20, 1'b0);
    for (int it = 0; it < 3; it++)
      run_scan(4'($urandom_range(15, 1)), $urandom_range(800, 200), $urandom_range(40, 1), 1'b0);

    // Empty mask: ticks are ignored.
    quiesce();
    cfg_ch_mask = 4'b0000; cfg_period = 16'd5;
    cfg_en = 1'b1;
    repeat (60) next_cyc();
    check_eq("mask0_starts", start_log.size(), 0);
    check_eq("mask0_frames", fd_log.size(), 0);

    // Host request from idle: start two cycles after request.
    quiesce();
    eng_delay = 15; hc = 2'($urandom_range(3, 0));
    @(posedge sys_clk); #1;
    host_ch = hc; host_req = 1'b1; h = cyc;
    c = 0;
    while (res_log.size() < 1 && c < 100) begin
      next_cyc();
      if (host_ack) host_req = 1'b0;
      c++;
    end
    check_eq("host_idle_done", res_log.size(), 1);
    check_eq("host_idle_start_lat", (start_log.size() > 0) ? start_log[0] : -1, h + 2);
    if (res_log.size() > 0 && done_dat.size() > 0) begin
      check_eq("host_idle_ch", res_log[0].ch, hc);
      check_eq("host_idle_host", res_log[0].host, 1);
      check_eq("host_idle_ack", res_log[0].ack, 1);
      check_eq("host_idle_data", res_log[0].data, {done_dat[0], 4'h0});
    end

    // Host request arriving while scan channel 0 converts.
    quiesce();
    eng_delay = 50; cfg_ch_mask = 4'b1111; cfg_period = 16'd1000;
    hc = 2'($urandom_range(3, 0));
    cfg_en = 1'b1;
    wait_starts(1, 1200, "hs_first_start");
    repeat (10) next_cyc();
    host_ch = hc; host_req = 1'b1;
    c = 0;
    while (res_log.size() < 5 && c < 800) begin
      next_cyc();
      if (host_ack) host_req = 1'b0;
      c++;
    end
    ech = '{0, int'(hc), 1, 2, 3};
    ehost = '{0, 1, 0, 0, 0};
    check_eq("hs_res_count", res_log.size(), 5);
    for (int i = 0; i < 5 && i < res_log.size() && i < done_dat.size(); i++) begin
      check_eq($sformatf("hs_ch[%0d]", i), res_log[i].ch, ech[i]);
      check_eq($sformatf("hs_host[%0d]", i), res_log[i].host, ehost[i]);
      check_eq($sformatf("hs_ack[%0d]", i), res_log[i].ack, ehost[i]);
      check_eq($sformatf("hs_data[%0d]", i), res_log[i].data, {done_dat[i], 4'h0});
      check_eq($sformatf("hs_fd[%0d]", i), res_log[i].fd, 32'(i == 4));
    end

    // Period shorter than a scan: overrun on first dropped tick, frames continue.
    quiesce();
    eng_delay = 36; cfg_ch_mask = 4'b1111; cfg_period = 16'd10;
    cfg_en = 1'b1;
    wait_starts(1, 100, "ovr_first_start");
    s = (start_log.size() > 0) ? start_log[0] : 0;
    while (cyc < s + 8) next_cyc();
    check_eq("ovr_before_drop", overrun, 0);
    next_cyc();
    check_eq("ovr_on_drop", overrun, 1);
    wait_frames(2, 1000, "ovr_frames_continue");
    check_eq("ovr_sticky", overrun, 1);

    // Engine never answers channel 0: timeout, zero result, channel 1 proceeds.
    quiesce();
    eng_mute = 1'b1; cfg_ch_mask = 4'b0011; cfg_period = 16'd5000; eng_delay = 12;
    cfg_en = 1'b1;
    wait_starts(1, 5100, "tmo_first_start");
    s = (start_log.size() > 0) ? start_log[0] : 0;
    while (cyc < s + 4096) next_cyc();
    check_eq("tmo_before", timeout_err, 0);
    next_cyc();
    check_eq("tmo_set", timeout_err, 1);
    eng_mute = 1'b0;
    wait_frames(1, 200, "tmo_frame");
    check_eq("tmo_res_count", res_log.size(), 2);
    if (res_log.size() >= 2 && done_dat.size() >= 1) begin
      check_eq("tmo_res_cyc", res_log[0].cyc, s + 4097);
      check_eq("tmo_res_ch", res_log[0].ch, 0);
      check_eq("tmo_res_data", res_log[0].data, 0);
      check_eq("tmo_next_ch", res_log[1].ch, 1);
      check_eq("tmo_next_data", res_log[1].data, {done_dat[0], 4'h0});
      check_eq("tmo_next_fd", res_log[1].fd, 1);
    end

    // Reset during WAIT clears everything; restart waits for the first tick.
    quiesce();
    eng_delay = 50; cfg_ch_mask = 4'b1111; cfg_period = 16'd20;
    cfg_en = 1'b1;
    wait_starts(1, 100, "rst_first_start");
    repeat (5) next_cyc();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outputs", outs_vec(), 32'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    r = cyc;
    start_log.delete(); res_log.delete();
    wait_starts(1, 100, "rst_restart");
    check_eq("rst_restart_lat", (start_log.size() > 0) ? start_log[0] : -1, r + 23);
    check_eq("rst_no_stray_res", res_log.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
